cmd_sender_n: RTL and testbench



---
 rtl/cmd_sender_pkg.sv | 19 +
 rtl/cmd_sender_n.sv | 187 ++++++++++++++++++
 tb/tb_cmd_sender_n.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_sender_pkg.sv
// Shared types and constants for the command sender: FSM state encoding,
// byte width and a counter-width helper.
package cmd_sender_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_RX
    } state_t;

    // Bits needed to count 0..bound-1, never less than one.
    function automatic int cnt_w(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/cmd_sender_n.sv
// Serialises a CMD_BYTES command through an external UART transmitter and
// optionally collects a RESP_BYTES response, with an optional inter-byte timeout.
module cmd_sender_n
    import cmd_sender_pkg::*;
#(
    parameter int CMD_BYTES   = 2,
    parameter int RESP_BYTES  = 1,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BYTE_W*CMD_BYTES-1:0]  cmd,
    input  logic                         send_cmd,
    input  logic                         expect_resp,
    input  logic                         clr_resp_rdy,
    output logic                         busy,
    output logic                         cmd_sent,
    output logic [BYTE_W*RESP_BYTES-1:0] resp,
    output logic                         resp_rdy,
    output logic                         timeout,
    output logic                         trmt,
    output logic [BYTE_W-1:0]            tx_data,
    input  logic                         tx_done,
    input  logic                         rx_rdy,
    input  logic [BYTE_W-1:0]            rx_data,
    output logic                         clr_rx_rdy
);

    localparam int CMD_W  = BYTE_W * CMD_BYTES;
    localparam int RESP_W = BYTE_W * RESP_BYTES;
    localparam int BCW    = cnt_w(CMD_BYTES);
    localparam int RCW    = cnt_w(RESP_BYTES);
    localparam int TCW    = cnt_w(TIMEOUT_CYC);
    localparam bit TO_EN  = (TIMEOUT_CYC > 0);

    localparam logic [BCW-1:0] BYTE_LAST = BCW'(CMD_BYTES - 1);
    localparam logic [RCW-1:0] RX_LAST   = RCW'(RESP_BYTES - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t             state_q, state_d;
    logic [CMD_W-1:0]   cmd_sh_q, cmd_sh_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [RCW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [TCW-1:0]     to_cnt_q, to_cnt_d;
    logic               exp_resp_q, exp_resp_d;
    logic [RESP_W-1:0]  resp_sh_q, resp_sh_d;
    logic [RESP_W-1:0]  resp_q, resp_d;
    logic               resp_rdy_q, resp_rdy_d;
    logic               cmd_sent_q, cmd_sent_d;
    logic               timeout_q, timeout_d;
    logic [RESP_W-1:0]  resp_push;

    function automatic logic [BYTE_W-1:0] lead_byte(input logic [CMD_W-1:0] w);
        if (MSB_FIRST != 0) return w[CMD_W-1 -: BYTE_W];
        else                return w[BYTE_W-1:0];
    endfunction

    function automatic logic [CMD_W-1:0] shift_cmd(input logic [CMD_W-1:0] w);
        if (MSB_FIRST != 0) return w << BYTE_W;
        else                return w >> BYTE_W;
    endfunction

    // The first byte received ends up at the end of the word that MSB_FIRST names.
    function automatic logic [RESP_W-1:0] push_resp(input logic [RESP_W-1:0] sh,
                                                    input logic [BYTE_W-1:0] b);
        if (MSB_FIRST != 0) return (sh << BYTE_W) | RESP_W'(b);
        else                return (sh >> BYTE_W) | (RESP_W'(b) << (RESP_W - BYTE_W));
    endfunction

    always_comb begin
        state_d    = state_q;
        cmd_sh_d   = cmd_sh_q;
        tx_data_d  = tx_data_q;
        byte_cnt_d = byte_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        to_cnt_d   = to_cnt_q;
        exp_resp_d = exp_resp_q;
        resp_sh_d  = resp_sh_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;
        cmd_sent_d = cmd_sent_q;
        timeout_d  = timeout_q;
        clr_rx_rdy = 1'b0;
        resp_push  = push_resp(resp_sh_q, rx_data);

        // Cleared first so that a set further down in the same cycle wins.
        if (clr_resp_rdy) resp_rdy_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (send_cmd) begin
                    cmd_sh_d   = shift_cmd(cmd);
                    tx_data_d  = lead_byte(cmd);
                    exp_resp_d = expect_resp;
                    cmd_sent_d = 1'b0;
                    resp_rdy_d = 1'b0;
                    timeout_d  = 1'b0;
                    clr_rx_rdy = 1'b1;
                    byte_cnt_d = '0;
                    rx_cnt_d   = '0;
                    to_cnt_d   = '0;
                    resp_sh_d  = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    if (byte_cnt_q != BYTE_LAST) begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        tx_data_d  = lead_byte(cmd_sh_q);
                        cmd_sh_d   = shift_cmd(cmd_sh_q);
                        state_d    = SEND;
                    end else begin
                        cmd_sent_d = 1'b1;
                        state_d    = exp_resp_q ? WAIT_RX : IDLE;
                    end
                end
            end
            WAIT_RX: begin
                if (rx_rdy) begin
                    clr_rx_rdy = 1'b1;
                    to_cnt_d   = '0;
                    resp_sh_d  = resp_push;
                    if (rx_cnt_q == RX_LAST) begin
                        resp_d     = resp_push;
                        resp_rdy_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end else if (TO_EN) begin
                    if (to_cnt_q == TO_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_sh_q   <= '0;
            tx_data_q  <= '0;
            byte_cnt_q <= '0;
            rx_cnt_q   <= '0;
            to_cnt_q   <= '0;
            exp_resp_q <= 1'b0;
            resp_sh_q  <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
            cmd_sent_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_sh_q   <= cmd_sh_d;
            tx_data_q  <= tx_data_d;
            byte_cnt_q <= byte_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            to_cnt_q   <= to_cnt_d;
            exp_resp_q <= exp_resp_d;
            resp_sh_q  <= resp_sh_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
            cmd_sent_q <= cmd_sent_d;
            timeout_q  <= timeout_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign trmt     = (state_q == SEND);
    assign tx_data  = tx_data_q;
    assign cmd_sent = cmd_sent_q;
    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_cmd_sender_n.sv
// Bench for cmd_sender_n: unit 0 is 2-byte MSB-first with a 20-cycle timeout,
// unit 1 is 4-byte LSB-first with a 3-byte response and no timeout.
module tb_cmd_sender_n;

    typedef struct {
        int          u;
        logic [31:0] c;
        bit          er;
        int          nrx;
        logic [7:0]  rx [3];
        int          gap;
        int          lat;
        bit          poke;
        bit          hold_clr;
        logic [7:0]  eb [4];
        logic [23:0] eresp;
        bit          eto;
    } vec_t;

    localparam int TO_A = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_v    [2];
    logic        send_v   [2];
    logic        exp_v    [2];
    logic        clrr_v   [2];
    logic        txdone_v [2];
    logic        rxrdy_v  [2];
    logic [7:0]  rxd_v    [2];
    logic        busy_v   [2];
    logic        sent_v   [2];
    logic        rrdy_v   [2];
    logic        to_v     [2];
    logic        trmt_v   [2];
    logic        clr_v    [2];
    logic [7:0]  txd_v    [2];
    logic [15:0] resp_a;
    logic [23:0] resp_b;

    int          total = 0;
    int          bad = 0;
    int          trmt_cnt [2] = '{0, 0};
    int          clr_cnt  [2] = '{0, 0};
    logic [23:0] last_resp [2];
    vec_t        tbl [$];

    always #5 clk = ~clk;

    cmd_sender_n #(.CMD_BYTES(2), .RESP_BYTES(2), .MSB_FIRST(1), .TIMEOUT_CYC(TO_A)) dut_a (
        .clk(clk), .rst(rst), .cmd(cmd_v[0][15:0]), .send_cmd(send_v[0]),
        .expect_resp(exp_v[0]), .clr_resp_rdy(clrr_v[0]), .busy(busy_v[0]),
        .cmd_sent(sent_v[0]), .resp(resp_a), .resp_rdy(rrdy_v[0]), .timeout(to_v[0]),
        .trmt(trmt_v[0]), .tx_data(txd_v[0]), .tx_done(txdone_v[0]),
        .rx_rdy(rxrdy_v[0]), .rx_data(rxd_v[0]), .clr_rx_rdy(clr_v[0])
    );

    cmd_sender_n #(.CMD_BYTES(4), .RESP_BYTES(3), .MSB_FIRST(0), .TIMEOUT_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .cmd(cmd_v[1]), .send_cmd(send_v[1]),
        .expect_resp(exp_v[1]), .clr_resp_rdy(clrr_v[1]), .busy(busy_v[1]),
        .cmd_sent(sent_v[1]), .resp(resp_b), .resp_rdy(rrdy_v[1]), .timeout(to_v[1]),
        .trmt(trmt_v[1]), .tx_data(txd_v[1]), .tx_done(txdone_v[1]),
        .rx_rdy(rxrdy_v[1]), .rx_data(rxd_v[1]), .clr_rx_rdy(clr_v[1])
    );

    // Pulse counters, sampled mid-low-phase when inputs and outputs are settled.
    always begin
        @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            if (trmt_v[k]) trmt_cnt[k]++;
            if (clr_v[k])  clr_cnt[k]++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1);
    end

    function automatic logic [23:0] resp_of(input int u);
        return (u == 0) ? {8'h00, resp_a} : resp_b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int u, input logic [31:0] c, input bit er, input int nrx,
                                input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                                input int gap, input int lat, input bit poke, input bit hold,
                                input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                input logic [7:0] e3, input logic [23:0] eresp, input bit eto);
        vec_t v;
        v.u = u; v.c = c; v.er = er; v.nrx = nrx;
        v.rx[0] = r0; v.rx[1] = r1; v.rx[2] = r2;
        v.gap = gap; v.lat = lat; v.poke = poke; v.hold_clr = hold;
        v.eb[0] = e0; v.eb[1] = e1; v.eb[2] = e2; v.eb[3] = e3;
        v.eresp = eresp; v.eto = eto;
        return v;
    endfunction

    // Reference: byte j of the transfer is the (N-1-j)-th or j-th byte of the word.
    function automatic vec_t model(input vec_t v);
        int nb, nr, idx;
        bit msb;
        msb = (v.u == 0);
        nb  = msb ? 2 : 4;
        nr  = msb ? 2 : 3;
        for (int j = 0; j < 4; j++) v.eb[j] = 8'h00;
        for (int j = 0; j < nb; j++) begin
            idx = msb ? (nb - 1 - j) : j;
            v.eb[j] = 8'((v.c >> (8 * idx)) & 32'hFF);
        end
        v.eresp = '0;
        for (int j = 0; j < nr; j++) begin
            idx = msb ? (nr - 1 - j) : j;
            v.eresp = v.eresp + (24'(v.rx[j]) << (8 * idx));
        end
        v.eto = v.er && (v.nrx < nr);
        return v;
    endfunction

    // Entered and left on a falling edge.
    task automatic run_txn(input vec_t v);
        int u, nb, nr, t0, c0, lat;
        logic [7:0] b;
        u   = v.u;
        nb  = (u == 0) ? 2 : 4;
        nr  = (u == 0) ? 2 : 3;
        lat = (v.lat < 1) ? 1 : v.lat;
        if (v.poke && lat < 2) lat = 2;
        t0 = trmt_cnt[u];
        c0 = clr_cnt[u];

        cmd_v[u] = v.c; exp_v[u] = v.er; send_v[u] = 1'b1;
        #1;
        chk("flush", 32'(clr_v[u]), 1);
        @(negedge clk);
        send_v[u] = 1'b0;
        chk("flags_clr", {29'd0, sent_v[u], rrdy_v[u], to_v[u]}, 0);
        chk("busy_run", 32'(busy_v[u]), 1);

        for (int j = 0; j < nb; j++) begin
            chk("trmt_lat", 32'(trmt_v[u]), 1);
            b = txd_v[u];
            chk("tx_byte", 32'(b), 32'(v.eb[j]));
            txdone_v[u] = 1'b0;
            for (int w = 0; w < lat; w++) begin
                @(negedge clk);
                if (v.poke && j == 0 && w == 0) begin
                    send_v[u] = 1'b1;
                    cmd_v[u]  = ~v.c;
                    #1;
                    chk("poke_noflush", 32'(clr_v[u]), 0);
                end else if (v.poke && j == 0 && w == 1) begin
                    send_v[u] = 1'b0;
                    cmd_v[u]  = v.c;
                end
            end
            chk("tx_hold", 32'(txd_v[u]), 32'(b));
            txdone_v[u] = 1'b1;
            @(negedge clk);
        end
        chk("cmd_sent", 32'(sent_v[u]), 1);
        chk("busy_end", 32'(busy_v[u]), 32'(v.er));
        chk("trmt_cnt", 32'(trmt_cnt[u] - t0), 32'(nb));

        if (v.er) begin
            if (v.hold_clr) clrr_v[u] = 1'b1;
            for (int j = 0; j < v.nrx; j++) begin
                repeat (v.gap) @(negedge clk);
                rxd_v[u] = v.rx[j]; rxrdy_v[u] = 1'b1;
                #1;
                chk("rx_clr", 32'(clr_v[u]), 1);
                @(negedge clk);
                rxrdy_v[u] = 1'b0;
            end
            clrr_v[u] = 1'b0;
            if (!v.eto) begin
                chk("resp_rdy", 32'(rrdy_v[u]), 1);
                chk("resp", 32'(resp_of(u)), 32'(v.eresp));
                chk("idle_after_rx", {30'd0, busy_v[u], to_v[u]}, 0);
                last_resp[u] = v.eresp;
                clrr_v[u] = 1'b1;
                @(negedge clk);
                clrr_v[u] = 1'b0;
                chk("clr_resp", 32'(rrdy_v[u]), 0);
                chk("resp_keep", 32'(resp_of(u)), 32'(v.eresp));
            end else begin
                for (int t = 2; t <= TO_A + 1; t++) begin
                    @(negedge clk);
                    if (t == TO_A) chk("to_early", 32'(to_v[u]), 0);
                end
                chk("to_fire", 32'(to_v[u]), 1);
                chk("to_state", {30'd0, busy_v[u], rrdy_v[u]}, 0);
                chk("to_resp", 32'(resp_of(u)), 32'(last_resp[u]));
            end
        end
        chk("clr_cnt", 32'(clr_cnt[u] - c0), 32'(1 + (v.er ? v.nrx : 0)));
    endtask

    initial begin
        int c0;
        vec_t v;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cmd_v[k] = '0; send_v[k] = 1'b0; exp_v[k] = 1'b0; clrr_v[k] = 1'b0;
            txdone_v[k] = 1'b0; rxrdy_v[k] = 1'b0; rxd_v[k] = '0; last_resp[k] = '0;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_flags", {26'd0, busy_v[k], sent_v[k], rrdy_v[k], to_v[k], trmt_v[k], clr_v[k]}, 0);
            chk("reset_data", {txd_v[k], resp_of(k)}, 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        tbl.push_back(mk(0, 32'h0000A55A, 0, 0, 8'h00, 8'h00, 8'h00, 0, 2, 0, 0,
                         8'hA5, 8'h5A, 8'h00, 8'h00, 24'h000000, 0));
        tbl.push_back(mk(1, 32'h11223344, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3, 0, 0,
                         8'h44, 8'h33, 8'h22, 8'h11, 24'h000000, 0));
        tbl.push_back(mk(0, 32'h00001234, 1, 2, 8'hBE, 8'hEF, 8'h00, 2, 1, 0, 0,
                         8'h12, 8'h34, 8'h00, 8'h00, 24'h00BEEF, 0));
        tbl.push_back(mk(0, 32'h0000CAFE, 1, 1, 8'h99, 8'h00, 8'h00, 3, 1, 0, 0,
                         8'hCA, 8'hFE, 8'h00, 8'h00, 24'h000000, 1));
        tbl.push_back(mk(0, 32'h00006789, 0, 0, 8'h00, 8'h00, 8'h00, 0, 3, 1, 0,
                         8'h67, 8'h89, 8'h00, 8'h00, 24'h000000, 0));
        tbl.push_back(mk(0, 32'h00002468, 1, 2, 8'h01, 8'h80, 8'h00, 19, 1, 0, 1,
                         8'h24, 8'h68, 8'h00, 8'h00, 24'h000180, 0));
        tbl.push_back(mk(1, 32'hDEADBEEF, 1, 3, 8'h01, 8'h02, 8'h03, 30, 1, 0, 0,
                         8'hEF, 8'hBE, 8'hAD, 8'hDE, 24'h030201, 0));
        tbl.push_back(mk(1, 32'h00000001, 1, 3, 8'hAA, 8'h00, 8'hFF, 0, 1, 1, 0,
                         8'h01, 8'h00, 8'h00, 8'h00, 24'hFF00AA, 0));

        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset while waiting on the first byte of a transfer.
        cmd_v[0] = 32'h0000C33C; exp_v[0] = 1'b1; send_v[0] = 1'b1;
        @(negedge clk);
        send_v[0] = 1'b0;
        chk("rst_seq_byte0", {23'd0, trmt_v[0], txd_v[0]}, {23'd0, 1'b1, 8'hC3});
        txdone_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_flags", {26'd0, busy_v[0], sent_v[0], rrdy_v[0], to_v[0], trmt_v[0], clr_v[0]}, 0);
        chk("rst_mid_data", {txd_v[0], resp_of(0)}, 0);
        last_resp[0] = '0;
        @(negedge clk);
        rst = 1'b0;
        txdone_v[0] = 1'b1;
        c0 = trmt_cnt[0];
        repeat (5) @(negedge clk);
        chk("rst_no_trmt", 32'(trmt_cnt[0] - c0), 0);
        run_txn(mk(0, 32'h0000C33C, 1, 1, 8'h5C, 8'h00, 8'h00, 4, 2, 0, 0,
                   8'hC3, 8'h3C, 8'h00, 8'h00, 24'h000000, 1));

        // A received byte while idle is left in the UART.
        rxd_v[1] = 8'h77; rxrdy_v[1] = 1'b1;
        #1;
        chk("rx_idle_ignored", 32'(clr_v[1]), 0);
        c0 = clr_cnt[1];
        repeat (3) @(negedge clk);
        chk("rx_idle_cnt", 32'(clr_cnt[1] - c0), 0);
        rxrdy_v[1] = 1'b0;

        for (int i = 0; i < 40; i++) begin
            v.u        = i % 2;
            v.c        = $urandom;
            v.er       = 1'($urandom_range(0, 1));
            v.nrx      = (v.u == 0) ? 2 : 3;
            if (v.u == 0 && $urandom_range(0, 3) == 0) v.nrx = 1;
            for (int j = 0; j < 3; j++) v.rx[j] = 8'($urandom);
            v.gap      = (v.u == 0) ? $urandom_range(0, 19) : $urandom_range(0, 30);
            v.lat      = $urandom_range(1, 4);
            v.poke     = ($urandom_range(0, 4) == 0);
            v.hold_clr = ($urandom_range(0, 3) == 0);
            run_txn(model(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
